bounce_gen: RTL
===============

BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter NUM_BOUNCE, default 5, number of out transitions per event, legal range 1..255; the last transition lands on the target level.
REQ-002 Parameter GAP_W, default 3, gap counter width; every inter-transition gap is 1..2^GAP_W cycles.
REQ-003 Parameter SETTLE_CYC, default 16, stable-hold cycles after the last transition, legal range >=1.
REQ-004 Parameter SEED, default 16'hACE1, LFSR reset value, must be nonzero.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  one-cycle request to emit a bouncing transition; sampled only in IDLE.
REQ-008 level  input  1  target settled level, captured with start.
REQ-009 out  output  1  bouncy waveform, registered, intended to feed a debouncer's inp.
REQ-010 busy  output  1  high in BOUNCE and SETTLE.
REQ-011 done  output  1  one-cycle pulse when SETTLE completes.

Function
REQ-012 FSM states SHALL be IDLE, BOUNCE and SETTLE, with no other reachable state.
REQ-013 IDLE: out holds its last value, busy=0, done=0; start=1 captures level into tgt, clears bounce count, loads the gap counter with G, and moves to BOUNCE on the same edge.
REQ-014 BOUNCE: the gap counter decrements each cycle; on the edge where it would reach 0, the counter reloads with a new G and the bounce count increments.
REQ-015 On that edge, out toggles if the incremented count < NUM_BOUNCE; otherwise out <= tgt, the settle counter loads SETTLE_CYC, and the state moves to SETTLE.
REQ-016 The final transition forces tgt regardless of parity; if out already equals tgt, out holds and no edge is produced.
REQ-017 SETTLE: out is constant at tgt; the counter decrements; on the edge it reaches 0, done=1 for that cycle, busy=0, and the state returns to IDLE.
REQ-018 start while busy=1 SHALL be ignored, with no queuing; start in the same cycle that done is asserted SHALL also be ignored.
REQ-019 A new start SHALL be accepted on the cycle after done.
REQ-020 With level equal to the current out, the full sequence SHALL still run (NUM_BOUNCE-1 glitches, then settle).
REQ-021 The total event length SHALL be sum(G_i, i=1..NUM_BOUNCE) + SETTLE_CYC cycles from the start edge to the done edge.
REQ-022 The gap counter SHALL be GAP_W+1 bits wide so that the value 2^GAP_W is representable; no counter shall wrap.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, out=0, busy=0, done=0, all counters to 0, tgt=0 and LFSR=SEED, in any state and with priority over start.
REQ-024 Reset mid-BOUNCE or mid-SETTLE SHALL abort the event with no done pulse; out=0 on the cycle after the reset edge.

Configuration
REQ-025 With macro BOUNCE_GEN_LFSR_EN defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0) SHALL advance every non-reset cycle, and G = LFSR[GAP_W-1:0] + 1, sampled at each load.
REQ-026 Without BOUNCE_GEN_LFSR_EN, no LFSR logic SHALL exist and G = 2^GAP_W fixed, making the waveform fully deterministic.

Verification
REQ-027 Macro undefined, defaults: rst, then start=1 with level=1 at edge 0 -> out toggles at edges 8,16,24,32; out=1 from edge 40; done pulse after edge 56; busy high over edges 0..55.
REQ-028 Same settings, level=0 from out=1 -> out reaches 0 at edge 40, with 4 intermediate toggles, final 0, and done after edge 56.
REQ-029 start pulses at edges 3, 20 and 56 of an event -> all are ignored; a start at edge 57 starts a new event.
REQ-030 rst asserted at edge 20 of an event -> out=0, busy=0, no done pulse; a start at edge 22 gives a normal 56-cycle event.
REQ-031 Macro defined, SEED=16'hACE1 -> every gap is within 1..8, out after the last transition equals level, and event length equals the gap sum + 16, checked against a reference LFSR model.
REQ-032 NUM_BOUNCE=1, level=1 from out=0 -> a single edge at G, then done after G+16 cycles.

Source files
------------

// File: rtl/bounce_gen.sv
// Bouncy edge generator: emits NUM_BOUNCE transitions with gaps between them, then holds the
// target level for SETTLE_CYC cycles. Define BOUNCE_GEN_LFSR_EN for pseudo-random gaps.
module bounce_gen #(
    parameter int unsigned NUM_BOUNCE = 5,
    parameter int unsigned GAP_W      = 3,
    parameter int unsigned SETTLE_CYC = 16,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic level,
    output logic out,
    output logic busy,
    output logic done
);

    localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
    localparam logic [SetW-1:0]  SetLoad = SetW'(SETTLE_CYC);
    localparam logic [SetW-1:0]  SetOne  = {{(SetW-1){1'b0}}, 1'b1};
    localparam logic [GAP_W:0]   GapOne  = {{GAP_W{1'b0}}, 1'b1};
    localparam logic [7:0]       NbLast  = 8'(NUM_BOUNCE);

    typedef enum logic [1:0] {StIdle, StBounce, StSettle} state_e;

    state_e          state_q, state_d;
    logic            out_q, out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tgt_q, tgt_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      cnt_inc;
    logic [GAP_W:0]  gap_q, gap_d;
    logic [SetW-1:0] set_q, set_d;
    logic [GAP_W:0]  g_val;

`ifdef BOUNCE_GEN_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    // x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        g_val  = {1'b0, lfsr_q[GAP_W-1:0]} + GapOne;
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign g_val = {1'b1, {GAP_W{1'b0}}};
`endif

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        set_d   = set_q;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    tgt_d   = level;
                    cnt_d   = 8'd0;
                    gap_d   = g_val;
                    busy_d  = 1'b1;
                    state_d = StBounce;
                end
            end
            StBounce: begin
                if (gap_q == GapOne) begin
                    gap_d = g_val;
                    cnt_d = cnt_inc;
                    if (cnt_inc < NbLast) begin
                        out_d = ~out_q;
                    end else begin
                        // Final transition lands on the target whatever the toggle parity
                        out_d   = tgt_q;
                        set_d   = SetLoad;
                        state_d = StSettle;
                    end
                end else begin
                    gap_d = gap_q - GapOne;
                end
            end
            StSettle: begin
                if (set_q == SetOne) begin
                    set_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    set_d = set_q - SetOne;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tgt_q   <= 1'b0;
            cnt_q   <= 8'd0;
            gap_q   <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            set_q   <= set_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
